// File: rtl/tx_sched_pkg.sv
// Shared constants, state encoding and helpers for the PSK frame scheduler.
package tx_sched_pkg;

  localparam logic [3:0] MODE_BPSK = 4'b0001;
  localparam logic [3:0] MODE_QPSK = 4'b0010;
  localparam logic [3:0] MODE_MIX  = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_GUARD,
    ST_PAY,
    ST_TAIL
  } state_t;

  // PN5 generator x^5 + x^3 + 1, serial output taken from bit 4
  localparam logic [4:0]  LFSR_SEED  = 5'b11111;
  localparam int unsigned LFSR_TAP_A = 4;
  localparam int unsigned LFSR_TAP_B = 2;

  function automatic logic mode_legal(input logic [3:0] m);
    return (m == MODE_BPSK) || (m == MODE_QPSK) || (m == MODE_MIX);
  endfunction

  function automatic logic [4:0] lfsr_step(input logic [4:0] s);
    return {s[3:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/pn5_lfsr.sv
// 5-bit Fibonacci PN generator. bit_o is the bit emitted on the current edge;
// a load emits seed[4], and both load and enable leave the register advanced.
module pn5_lfsr
  import tx_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [4:0] seed_i,
  output logic       bit_o
);

  logic [4:0] lfsr_q, lfsr_d;

  // Select emitted bit and next register value
  always_comb begin
    lfsr_d = lfsr_q;
    bit_o  = lfsr_q[4];
    if (load_i) begin
      bit_o  = seed_i[4];
      lfsr_d = lfsr_step(seed_i);
    end else if (en_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // Shift register state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/tx_frame_sched.sv
// Frame scheduler: PN preamble -> guard -> payload -> tail, one symbol per
// SYM_CYCLES clocks, with mode policy, DAC gating and phase latching.
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter int unsigned SYM_CYCLES = 128,
  parameter int unsigned PRE_LEN    = 31,
  parameter int unsigned TAIL_SYMS  = 2
) (
  input  logic        clk_16M384,
  input  logic        rst_16M384,
  input  logic [3:0]  MODE_CTRL,
  input  logic [3:0]  DELAY_CNT,
  input  logic [15:0] TX_PHASE_CONFIG,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic        sym_stb,
  output logic [1:0]  sym_bits,
  output logic        sym_qpsk,
  output logic        dac_vld,
  output logic [15:0] phase_inc,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [1:0]  err
);

  localparam int unsigned TW = $clog2(SYM_CYCLES);

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    scnt_q;
  logic [3:0]    mode_q, dly_q;
  logic [15:0]   phase_q;
  logic [7:0]    hold_q, sh_q;
  logic          hold_vld_q, hold_last_q, sh_last_q, last_acc_q, abort_q;
  logic          sym_stb_q, sym_qpsk_q, dac_q, done_q;
  logic [1:0]    bits_q, err_q;

  logic          wrap, acc, pn_bit, lfsr_load, lfsr_en, pay_load;
  logic          pre_qpsk, pay_qpsk, pre_end, guard_end, byte_end, tail_end;
  logic          hold_avail, hold_lastv;
  logic [7:0]    hold_byte, ld_shift, sh_next;
  logic [1:0]    ld_bits, sh_bits, pre_bits;

  // Handshake, symbol-boundary decode and next-symbol bit selection.
  // A byte accepted on the cycle of a byte boundary is forwarded straight
  // into the shift register so it is not mistaken for an underrun.
  always_comb begin
    s_tready = 1'b0;
    case (state_q)
      ST_IDLE:                  s_tready = mode_legal(MODE_CTRL);
      ST_PRE, ST_GUARD, ST_PAY: s_tready = !hold_vld_q && !last_acc_q;
      default:                  s_tready = 1'b0;
    endcase
    s_tready   = s_tready && !rst_16M384;
    acc        = s_tvalid && s_tready;
    wrap       = (state_q != ST_IDLE) && (timer_q == TW'(SYM_CYCLES - 1));

    pre_qpsk   = (state_q == ST_IDLE) ? (MODE_CTRL == MODE_QPSK) : (mode_q == MODE_QPSK);
    pre_bits   = pre_qpsk ? {pn_bit, pn_bit} : {1'b0, pn_bit};
    pay_qpsk   = (mode_q != MODE_BPSK);

    hold_avail = hold_vld_q || acc;
    hold_byte  = hold_vld_q ? hold_q : s_tdata;
    hold_lastv = hold_vld_q ? hold_last_q : s_tlast;
    ld_bits    = pay_qpsk ? hold_byte[7:6] : {1'b0, hold_byte[7]};
    ld_shift   = pay_qpsk ? {hold_byte[5:0], 2'b00} : {hold_byte[6:0], 1'b0};
    sh_bits    = pay_qpsk ? sh_q[7:6] : {1'b0, sh_q[7]};
    sh_next    = pay_qpsk ? {sh_q[5:0], 2'b00} : {sh_q[6:0], 1'b0};

    pre_end    = (scnt_q == 8'(PRE_LEN - 1));
    guard_end  = (scnt_q == 8'(dly_q) - 8'd1);
    byte_end   = (scnt_q == (pay_qpsk ? 8'd3 : 8'd7));
    tail_end   = (scnt_q == 8'(TAIL_SYMS - 1));

    pay_load   = wrap && (((state_q == ST_PRE) && pre_end && (dly_q == 4'd0)) ||
                          ((state_q == ST_GUARD) && guard_end) ||
                          ((state_q == ST_PAY) && byte_end && !sh_last_q && hold_avail));
    lfsr_load  = (state_q == ST_IDLE) && acc;
    lfsr_en    = wrap && (state_q == ST_PRE) && !pre_end;
  end

  pn5_lfsr u_pn (
    .clk_i  (clk_16M384),
    .rst_i  (rst_16M384),
    .load_i (lfsr_load),
    .en_i   (lfsr_en),
    .seed_i (LFSR_SEED),
    .bit_o  (pn_bit)
  );

  // One-byte holding register and per-frame tlast tracking
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      hold_last_q <= 1'b0;
      last_acc_q  <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (acc) begin
        hold_q      <= s_tdata;
        hold_vld_q  <= 1'b1;
        hold_last_q <= s_tlast;
        last_acc_q  <= s_tlast;
      end
    end else if (wrap && (state_q == ST_TAIL) && tail_end) begin
      hold_vld_q <= 1'b0;
      last_acc_q <= 1'b0;
    end else begin
      if (pay_load) begin
        hold_vld_q <= 1'b0;
      end else if (acc) begin
        hold_q      <= s_tdata;
        hold_vld_q  <= 1'b1;
        hold_last_q <= s_tlast;
      end
      if (acc) last_acc_q <= last_acc_q | s_tlast;
    end
  end

  // Frame FSM, symbol timer and registered symbol/status outputs
  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      scnt_q     <= '0;
      mode_q     <= '0;
      dly_q      <= '0;
      phase_q    <= '0;
      sh_q       <= '0;
      sh_last_q  <= 1'b0;
      abort_q    <= 1'b0;
      sym_stb_q  <= 1'b0;
      bits_q     <= '0;
      sym_qpsk_q <= 1'b0;
      dac_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      sym_stb_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= '0;
      if (state_q == ST_IDLE) begin
        timer_q <= '0;
        if (acc) begin
          state_q    <= ST_PRE;
          scnt_q     <= '0;
          mode_q     <= MODE_CTRL;
          dly_q      <= DELAY_CNT;
          phase_q    <= TX_PHASE_CONFIG;
          abort_q    <= 1'b0;
          sym_stb_q  <= 1'b1;
          bits_q     <= pre_bits;
          sym_qpsk_q <= pre_qpsk;
          dac_q      <= 1'b1;
        end else if (s_tvalid && !mode_legal(MODE_CTRL)) begin
          err_q[0] <= 1'b1;
        end
      end else begin
        timer_q <= wrap ? '0 : timer_q + TW'(1);
        if (wrap) begin
          sym_stb_q <= 1'b1;
          scnt_q    <= scnt_q + 8'd1;
          if (pay_load) begin
            state_q    <= ST_PAY;
            scnt_q     <= '0;
            bits_q     <= ld_bits;
            sym_qpsk_q <= pay_qpsk;
            dac_q      <= 1'b1;
            sh_q       <= ld_shift;
            sh_last_q  <= hold_lastv;
          end else begin
            case (state_q)
              ST_PRE: begin
                if (pre_end) begin
                  state_q    <= ST_GUARD;
                  scnt_q     <= '0;
                  bits_q     <= '0;
                  sym_qpsk_q <= 1'b0;
                  dac_q      <= 1'b0;
                end else begin
                  bits_q <= pre_bits;
                end
              end
              ST_GUARD: bits_q <= '0;
              ST_PAY: begin
                if (byte_end) begin
                  state_q    <= ST_TAIL;
                  scnt_q     <= '0;
                  bits_q     <= '0;
                  sym_qpsk_q <= 1'b0;
                  if (!sh_last_q) begin
                    abort_q  <= 1'b1;
                    err_q[1] <= 1'b1;
                  end
                end else begin
                  bits_q <= sh_bits;
                  sh_q   <= sh_next;
                end
              end
              ST_TAIL: begin
                bits_q <= '0;
                if (tail_end) begin
                  state_q   <= ST_IDLE;
                  scnt_q    <= '0;
                  sym_stb_q <= 1'b0;
                  dac_q     <= 1'b0;
                  done_q    <= !abort_q;
                end
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
      end
    end
  end

  assign sym_stb    = sym_stb_q;
  assign sym_bits   = bits_q;
  assign sym_qpsk   = sym_qpsk_q;
  assign dac_vld    = dac_q;
  assign phase_inc  = phase_q;
  assign frame_busy = (state_q != ST_IDLE);
  assign frame_done = done_q;
  assign err        = err_q;

endmodule
